split_sample_gen: RTL and testbench



---
 rtl/split_sample_gen.sv | 110 +++++++++++
 tb/tb_split_sample_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/split_sample_gen.sv
// rtl/split_sample_gen.sv - LFSR-driven search for values satisfying the split predicate
module split_sample_gen #(
    parameter int               WIDTH     = 15,
    parameter int               SHIFT     = 10,
    parameter logic [WIDTH-1:0] SEED      = 15'h0001,
    parameter int               MAX_TRIES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             busy,
    output logic             fail,
    output logic [6:0]       tries
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2,
        FAIL   = 2'd3
    } state_t;

    localparam logic [6:0]       TRY_LIMIT = 7'(MAX_TRIES);
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [WIDTH-1:0] lfsr, lfsr_n;
    logic [WIDTH-1:0] out_value_n;
    logic             out_valid_n;
    logic             fail_n;
    logic [6:0]       tries_n;
    logic [6:0]       tries_inc;

    function automatic logic sat(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] inv;
        inv = ~v;
        return |(inv >> SHIFT);
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1] ^ v[WIDTH-2]};
    endfunction

    assign tries_inc = tries + 7'd1;
    assign busy      = (state == SEARCH) || (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED;
            out_valid <= 1'b0;
            out_value <= '0;
            fail      <= 1'b0;
            tries     <= 7'd0;
        end else begin
            state     <= state_n;
            lfsr      <= lfsr_n;
            out_valid <= out_valid_n;
            out_value <= out_value_n;
            fail      <= fail_n;
            tries     <= tries_n;
        end
    end

    always_comb begin
        state_n     = state;
        lfsr_n      = lfsr;
        out_valid_n = out_valid;
        out_value_n = out_value;
        fail_n      = fail;
        tries_n     = tries;
        case (state)
            IDLE, FAIL: begin
                // A zero seed would lock the LFSR, so it is coerced to one.
                if (seed_load)
                    lfsr_n = (seed_in == '0) ? ONE : seed_in;
                if (start) begin
                    state_n = SEARCH;
                    tries_n = 7'd0;
                    fail_n  = 1'b0;
                end
            end
            SEARCH: begin
                lfsr_n  = lfsr_step(lfsr);
                tries_n = tries_inc;
                if (sat(lfsr)) begin
                    out_value_n = lfsr;
                    out_valid_n = 1'b1;
                    state_n     = HOLD;
                end else if (tries_inc == TRY_LIMIT) begin
                    fail_n  = 1'b1;
                    state_n = FAIL;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_split_sample_gen.sv
// tb/tb_split_sample_gen.sv - directed bench for split_sample_gen
module tb_split_sample_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        seed_load = 1'b0;
    logic [14:0] seed_in = '0;
    logic        out_ready = 1'b1;

    logic        out_valid, busy, fail;
    logic [14:0] out_value;
    logic [6:0]  tries;

    logic        out_valid1, busy1, fail1;
    logic [14:0] out_value1;
    logic [6:0]  tries1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    split_sample_gen u_dut (
        .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .busy(busy), .fail(fail), .tries(tries)
    );

    split_sample_gen #(.MAX_TRIES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
        .out_valid(out_valid1), .out_ready(out_ready), .out_value(out_value1),
        .busy(busy1), .fail(fail1), .tries(tries1)
    );

    function automatic logic ref_sat(input logic [14:0] v);
        return v[14:10] != 5'b11111;
    endfunction

    // Pulses start for one edge; returns at the negedge after the start edge.
    task automatic request(input logic [14:0] s, input logic load);
        @(negedge clk);
        seed_in   = s;
        seed_load = load;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_value !== 15'h0) begin failures++; $display("FAIL reset_value got=%h exp=0", out_value); end
        checks++; if ({busy, fail} !== 2'b00) begin failures++; $display("FAIL reset_busy_fail got=%b exp=00", {busy, fail}); end
        checks++; if (tries !== 7'd0) begin failures++; $display("FAIL reset_tries got=%0d exp=0", tries); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        request(15'h0001, 1'b1);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_search got busy=%b valid=%b exp busy=1 valid=0", busy, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_value !== 15'h0001) begin failures++; $display("FAIL basic_value got=%h exp=0001", out_value); end
        checks++; if (tries !== 7'd1 || fail !== 1'b0) begin failures++; $display("FAIL basic_tries got tries=%0d fail=%b exp tries=1 fail=0", tries, fail); end
        checks++; if (!ref_sat(out_value)) begin failures++; $display("FAIL basic_sat got=%h exp=satisfying", out_value); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_idle got valid=%b busy=%b exp 0 0", out_valid, busy); end
    endtask

    task automatic test_second_candidate;
        out_ready = 1'b1;
        request(15'h7C00, 1'b1);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || tries !== 7'd1) begin failures++; $display("FAIL second_first got valid=%b tries=%0d exp valid=0 tries=1", out_valid, tries); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_value !== 15'h7800) begin failures++; $display("FAIL second_value got valid=%b value=%h exp 1 7800", out_valid, out_value); end
        checks++; if (tries !== 7'd2) begin failures++; $display("FAIL second_tries got=%0d exp=2", tries); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL second_release got=%b exp=0", out_valid); end
    endtask

    task automatic test_hold;
        out_ready = 1'b0;
        request(15'h7C00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_value !== 15'h7800 || busy !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable[%0d] got valid=%b value=%h busy=%b exp 1 7800 1", i, out_valid, out_value, busy);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL hold_release got valid=%b busy=%b exp 0 0", out_valid, busy); end
        checks++; if (tries !== 7'd2) begin failures++; $display("FAIL hold_tries got=%0d exp=2", tries); end
    endtask

    task automatic test_fail;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        request(15'h7C00, 1'b1);
        @(negedge clk);
        checks++; if (fail1 !== 1'b1 || tries1 !== 7'd1) begin failures++; $display("FAIL budget_fail got fail=%b tries=%0d exp 1 1", fail1, tries1); end
        checks++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL budget_outputs got valid=%b busy=%b exp 0 0", out_valid1, busy1); end
        @(negedge clk);
        checks++; if (fail1 !== 1'b1 || out_valid1 !== 1'b0) begin failures++; $display("FAIL budget_sticky got fail=%b valid=%b exp 1 0", fail1, out_valid1); end
        request(15'h0001, 1'b1);
        checks++; if (fail1 !== 1'b0) begin failures++; $display("FAIL budget_clear got=%b exp=0", fail1); end
        @(negedge clk);
        checks++; if (out_valid1 !== 1'b1 || out_value1 !== 15'h0001) begin failures++; $display("FAIL budget_retry got valid=%b value=%h exp 1 0001", out_valid1, out_value1); end
        @(negedge clk);
    endtask

    task automatic test_zero_seed;
        out_ready = 1'b1;
        request(15'h0000, 1'b1);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_value !== 15'h0001) begin failures++; $display("FAIL zero_seed got valid=%b value=%h exp 1 0001", out_valid, out_value); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        request(15'h7C00, 1'b1);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || tries !== 7'd1) begin failures++; $display("FAIL mid_pre got busy=%b tries=%0d exp 1 1", busy, tries); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_value !== 15'h0) begin failures++; $display("FAIL mid_rst_out got valid=%b value=%h exp 0 0000", out_valid, out_value); end
        checks++; if (busy !== 1'b0 || fail !== 1'b0 || tries !== 7'd0) begin failures++; $display("FAIL mid_rst_state got busy=%b fail=%b tries=%0d exp 0 0 0", busy, fail, tries); end
        @(negedge clk);
        rst = 1'b0;
        request(15'h7C00, 1'b0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_value !== 15'h0001) begin failures++; $display("FAIL mid_seed got valid=%b value=%h exp 1 0001", out_valid, out_value); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second_candidate();
        test_hold();
        test_fail();
        test_zero_seed();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
